// File: rtl/fpu_16.sv
// Half-precision (binary16) arithmetic unit: ADD/SUB/MUL/DIV/MIN/MAX/ABS/NEG with exception flags.
// Latency: two cycles (operands registered, then result/flags registered); one new operation per clock.
// Backpressure: none -- free-running pipeline, results read a fixed two edges after issue.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   a, b, opc       binary16 operands and 3-bit opcode (captured every edge)
//   op, edge_case   registered binary16 result and flags {invalid, div_by_zero, overflow, underflow}
module fpu_16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [2:0]  opc,
  output logic [15:0] op,
  output logic [3:0]  edge_case
);
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_DIV = 3'd3,
                         OP_MIN = 3'd4, OP_MAX = 3'd5, OP_ABS = 3'd6, OP_NEG = 3'd7;
  localparam logic [15:0] QNAN = 16'h7E00;

  logic [15:0] a_q, b_q;
  logic [2:0]  opc_q;
  logic [15:0] res_d;
  logic [3:0]  flg_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= 16'h0;
      b_q       <= 16'h0;
      opc_q     <= OP_ADD;
      op        <= 16'h0;
      edge_case <= 4'h0;
    end else begin
      a_q       <= a;
      b_q       <= b;
      opc_q     <= opc;
      op        <= res_d;
      edge_case <= flg_d;
    end
  end

  // Round-to-nearest-even and pack. sig is 1.f[9:0] followed by guard, round, sticky.
  // Returns {overflow, underflow, result}; a result too small for a normal flushes to signed zero.
  function automatic logic [17:0] round_pack(input logic s, input logic signed [9:0] e,
                                             input logic [13:0] sig);
    logic [11:0]       m;
    logic signed [9:0] ex;
    logic              up;
    up = sig[2] & (sig[1] | sig[0] | sig[3]);
    m  = {1'b0, sig[13:3]} + {11'd0, up};
    ex = e;
    if (m[11]) begin
      m  = m >> 1;
      ex = ex + 10'sd1;
    end
    if (ex >= 10'sd31)     round_pack = {1'b1, 1'b0, s, 5'h1F, 10'h0};
    else if (ex <= 10'sd0) round_pack = {1'b0, 1'b1, s, 15'h0};
    else                   round_pack = {2'b00, s, ex[4:0], m[9:0]};
  endfunction

  // Operand decode; subnormals are treated as zero (no hidden bit, zero mantissa).
  logic              sa, sb, sbe, za, zb, ia, ib, na, nb;
  logic [4:0]        ea, eb;
  logic [10:0]       ma, mb;
  logic signed [9:0] ea_s, eb_s;
  assign sa   = a_q[15];
  assign sb   = b_q[15];
  assign sbe  = sb ^ (opc_q == OP_SUB);
  assign ea   = a_q[14:10];
  assign eb   = b_q[14:10];
  assign za   = (ea == 5'd0);
  assign zb   = (eb == 5'd0);
  assign ia   = (ea == 5'd31) && (a_q[9:0] == 10'd0);
  assign ib   = (eb == 5'd31) && (b_q[9:0] == 10'd0);
  assign na   = (ea == 5'd31) && (a_q[9:0] != 10'd0);
  assign nb   = (eb == 5'd31) && (b_q[9:0] != 10'd0);
  assign ma   = za ? 11'd0 : {1'b1, a_q[9:0]};
  assign mb   = zb ? 11'd0 : {1'b1, b_q[9:0]};
  assign ea_s = $signed({5'd0, ea});
  assign eb_s = $signed({5'd0, eb});

  // ADD/SUB: order by magnitude so the difference is never negative, align the
  // smaller operand with sticky collection, then renormalise.
  logic              swap, xs, ys;
  logic [4:0]        xe, d;
  logic [10:0]       xm, ym;
  logic [13:0]       y_ext, y_sh, y_al, add_sig;
  logic [14:0]       key_a, key_b, sum;
  logic [3:0]        p, shamt;
  logic signed [9:0] add_e;
  logic [17:0]       add_pk;

  always_comb begin
    key_a = za ? 15'd0 : a_q[14:0];
    key_b = zb ? 15'd0 : b_q[14:0];
    swap  = key_b > key_a;
    xs    = swap ? sbe : sa;
    ys    = swap ? sa : sbe;
    xe    = swap ? eb : ea;
    xm    = swap ? mb : ma;
    ym    = swap ? ma : mb;
    d     = swap ? (eb - ea) : (ea - eb);
    y_ext = {ym, 3'b000};
    y_sh  = y_ext >> d;
    y_al  = {y_sh[13:1], y_sh[0] | (|(y_ext & ~({14{1'b1}} << d)))};
    sum   = (xs == ys) ? ({1'b0, xm, 3'b000} + {1'b0, y_al})
                       : ({1'b0, xm, 3'b000} - {1'b0, y_al});
    p = 4'd0;
    for (int i = 0; i < 15; i++) begin
      if (sum[i]) p = 4'(i);
    end
    shamt = 4'd0;
    if (sum[14]) begin
      add_sig = {sum[14:2], sum[1] | sum[0]};
      add_e   = $signed({5'd0, xe}) + 10'sd1;
    end else begin
      shamt   = 4'd13 - p;
      add_sig = sum[13:0] << shamt;
      add_e   = $signed({5'd0, xe}) - $signed({6'd0, shamt});
    end
    add_pk = round_pack(xs, add_e, add_sig);
  end

  // MUL: 11x11 mantissa product lies in [1,4).
  logic [21:0]       prod;
  logic [13:0]       mul_sig;
  logic signed [9:0] mul_e;
  logic [17:0]       mul_pk;

  always_comb begin
    prod  = {11'd0, ma} * {11'd0, mb};
    mul_e = ea_s + eb_s - 10'sd15;
    if (prod[21]) begin
      mul_sig = {prod[21:9], |prod[8:0]};
      mul_e   = mul_e + 10'sd1;
    end else begin
      mul_sig = {prod[20:8], |prod[7:0]};
    end
    mul_pk = round_pack(sa ^ sb, mul_e, mul_sig);
  end

  // DIV: ma*2^14/mb lies in (2^13, 2^15), giving at least 14 quotient bits;
  // the remainder folds into sticky.
  logic [24:0]       num;
  logic [10:0]       den, rem;
  logic [14:0]       q;
  logic [13:0]       div_sig;
  logic signed [9:0] div_e;
  logic [17:0]       div_pk;

  always_comb begin
    num = {ma, 14'd0};
    den = zb ? 11'd1 : mb;            // zero divisor is handled as a special case
    q   = 15'(num / {14'd0, den});
    rem = 11'(num % {14'd0, den});
    if (q[14]) begin
      div_sig = {q[14:2], (|q[1:0]) | (rem != 11'd0)};
      div_e   = ea_s - eb_s + 10'sd15;
    end else begin
      div_sig = {q[13:1], q[0] | (rem != 11'd0)};
      div_e   = ea_s - eb_s + 10'sd14;
    end
    div_pk = round_pack(sa ^ sb, div_e, div_sig);
  end

  // MIN/MAX total-order keys: -0 sorts below +0.
  logic [15:0] ka, kb;
  logic        a_lt;
  assign ka   = sa ? {1'b0, ~a_q[14:0]} : {1'b1, a_q[14:0]};
  assign kb   = sb ? {1'b0, ~b_q[14:0]} : {1'b1, b_q[14:0]};
  assign a_lt = ka < kb;

  always_comb begin
    res_d = 16'h0;
    flg_d = 4'h0;
    case (opc_q)
      OP_ADD, OP_SUB: begin
        if (na | nb)                     res_d = QNAN;
        else if (ia & ib & (sa != sbe)) begin res_d = QNAN; flg_d = 4'b1000; end
        else if (ia)                     res_d = a_q;
        else if (ib)                     res_d = {sbe, 15'h7C00};
        else if (za & zb)                res_d = {sa & sbe, 15'h0};
        else if (sum == 15'd0)           res_d = 16'h0;   // exact cancellation is +0
        else begin res_d = add_pk[15:0]; flg_d = {2'b00, add_pk[17:16]}; end
      end
      OP_MUL: begin
        if (na | nb)                     res_d = QNAN;
        else if ((za & ib) | (ia & zb)) begin res_d = QNAN; flg_d = 4'b1000; end
        else if (ia | ib)                res_d = {sa ^ sb, 15'h7C00};
        else if (za | zb)                res_d = {sa ^ sb, 15'h0};
        else begin res_d = mul_pk[15:0]; flg_d = {2'b00, mul_pk[17:16]}; end
      end
      OP_DIV: begin
        if (na | nb)                     res_d = QNAN;
        else if ((za & zb) | (ia & ib)) begin res_d = QNAN; flg_d = 4'b1000; end
        else if (zb) begin res_d = {sa ^ sb, 15'h7C00}; flg_d = 4'b0100; end
        else if (ia)                     res_d = {sa ^ sb, 15'h7C00};
        else if (ib | za)                res_d = {sa ^ sb, 15'h0};
        else begin res_d = div_pk[15:0]; flg_d = {2'b00, div_pk[17:16]}; end
      end
      OP_MIN, OP_MAX: begin
        if (na & nb)   res_d = QNAN;
        else if (na)   res_d = b_q;
        else if (nb)   res_d = a_q;
        else           res_d = ((opc_q == OP_MIN) == a_lt) ? a_q : b_q;
      end
      OP_ABS: res_d = {1'b0, a_q[14:0]};
      OP_NEG: res_d = {~a_q[15], a_q[14:0]};
    endcase
  end

endmodule

// File: tb/tb_fpu_16.sv
module tb_fpu_16;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b;
  logic [2:0]  opc;
  logic [15:0] op;
  logic [3:0]  edge_case;
  int          total = 0;
  int          bad   = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  opc;
    logic [15:0] eop;
    logic [3:0]  efl;
  } vec_t;

  fpu_16 dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .opc       (opc),
    .op        (op),
    .edge_case (edge_case)
  );

  always #5 clk = ~clk;

  // Apply one operation and wait out the two-edge latency, sampling 1 ns after the edge.
  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic [2:0] io);
    a = ia; b = ib; opc = io;
    @(posedge clk); @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; a = 16'($urandom); b = 16'($urandom); opc = 3'($urandom);
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (op !== 16'h0000) begin bad++; $display("FAIL reset_op got %h want 0000", op); end
    total++;
    if (edge_case !== 4'b0000) begin bad++; $display("FAIL reset_flags got %b want 0000", edge_case); end
    rst = 1'b0;
    issue(16'h3C00, 16'h4000, 3'b000);
    total++;
    if (op !== 16'h4200 || edge_case !== 4'b0000)
      begin bad++; $display("FAIL first_add got %h/%b want 4200/0000", op, edge_case); end
    // Reset in flight: an overflowing MUL is in stage 1 when reset hits; it must vanish.
    a = 16'h7BFF; b = 16'h4000; opc = 3'b010;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (op !== 16'h0000 || edge_case !== 4'b0000)
      begin bad++; $display("FAIL midreset_out got %h/%b want 0000/0000", op, edge_case); end
    rst = 1'b0; a = 16'h3C00; b = 16'h3C00; opc = 3'b000;
    @(posedge clk); #1;
    total++;
    if (op !== 16'h0000 || edge_case !== 4'b0000)
      begin bad++; $display("FAIL discard_inflight got %h/%b want 0000/0000", op, edge_case); end
    @(posedge clk); #1;
    total++;
    if (op !== 16'h4000 || edge_case !== 4'b0000)
      begin bad++; $display("FAIL after_reset_add got %h/%b want 4000/0000", op, edge_case); end
  endtask

  task automatic test_add_sub;
    vec_t v[8];
    v[0] = '{16'h3C00, 16'h3C00, 3'b001, 16'h0000, 4'b0000};  // exact cancellation
    v[1] = '{16'h4200, 16'h3C00, 3'b001, 16'h4000, 4'b0000};  // 3-1
    v[2] = '{16'h7C00, 16'hFC00, 3'b000, 16'h7E00, 4'b1000};  // inf + -inf
    v[3] = '{16'h3C00, 16'h1000, 3'b000, 16'h3C00, 4'b0000};  // tie, stays even
    v[4] = '{16'h3C01, 16'h1000, 3'b000, 16'h3C02, 4'b0000};  // tie, rounds to even
    v[5] = '{16'h8000, 16'h8000, 3'b000, 16'h8000, 4'b0000};  // -0 + -0
    v[6] = '{16'h7BFF, 16'h7BFF, 3'b000, 16'h7C00, 4'b0010};  // overflow
    v[7] = '{16'h7C00, 16'h7C00, 3'b001, 16'h7E00, 4'b1000};  // inf - inf
    foreach (v[i]) begin
      issue(v[i].a, v[i].b, v[i].opc);
      total++;
      if (op !== v[i].eop) begin bad++; $display("FAIL addsub[%0d] op got %h want %h", i, op, v[i].eop); end
      total++;
      if (edge_case !== v[i].efl) begin bad++; $display("FAIL addsub[%0d] flags got %b want %b", i, edge_case, v[i].efl); end
    end
  endtask

  task automatic test_mul;
    vec_t v[5];
    v[0] = '{16'h7BFF, 16'h4000, 3'b010, 16'h7C00, 4'b0010};  // overflow
    v[1] = '{16'h0400, 16'h0400, 3'b010, 16'h0000, 4'b0001};  // underflow
    v[2] = '{16'h7E00, 16'h3C00, 3'b010, 16'h7E00, 4'b0000};  // NaN operand
    v[3] = '{16'hC000, 16'h4200, 3'b010, 16'hC600, 4'b0000};  // -2*3
    v[4] = '{16'h0000, 16'h7C00, 3'b010, 16'h7E00, 4'b1000};  // 0*inf
    foreach (v[i]) begin
      issue(v[i].a, v[i].b, v[i].opc);
      total++;
      if (op !== v[i].eop) begin bad++; $display("FAIL mul[%0d] op got %h want %h", i, op, v[i].eop); end
      total++;
      if (edge_case !== v[i].efl) begin bad++; $display("FAIL mul[%0d] flags got %b want %b", i, edge_case, v[i].efl); end
    end
  endtask

  task automatic test_div;
    vec_t v[7];
    v[0] = '{16'h3C00, 16'h0000, 3'b011, 16'h7C00, 4'b0100};  // 1/0
    v[1] = '{16'h4200, 16'h4000, 3'b011, 16'h3E00, 4'b0000};  // 3/2
    v[2] = '{16'h0000, 16'h0000, 3'b011, 16'h7E00, 4'b1000};  // 0/0
    v[3] = '{16'h3C00, 16'h4200, 3'b011, 16'h3555, 4'b0000};  // 1/3, inexact
    v[4] = '{16'hBC00, 16'h7C00, 3'b011, 16'h8000, 4'b0000};  // -1/inf
    v[5] = '{16'h7C00, 16'h7C00, 3'b011, 16'h7E00, 4'b1000};  // inf/inf
    v[6] = '{16'hBC00, 16'h0000, 3'b011, 16'hFC00, 4'b0100};  // -1/0
    foreach (v[i]) begin
      issue(v[i].a, v[i].b, v[i].opc);
      total++;
      if (op !== v[i].eop) begin bad++; $display("FAIL div[%0d] op got %h want %h", i, op, v[i].eop); end
      total++;
      if (edge_case !== v[i].efl) begin bad++; $display("FAIL div[%0d] flags got %b want %b", i, edge_case, v[i].efl); end
    end
  endtask

  // One opcode per cycle; each result is checked in issue order two edges later.
  task automatic test_back_to_back;
    vec_t v[9];
    v[0] = '{16'hC000, 16'h3C00, 3'b100, 16'hC000, 4'b0000};
    v[1] = '{16'hC000, 16'h3C00, 3'b101, 16'h3C00, 4'b0000};
    v[2] = '{16'hC000, 16'h3C00, 3'b110, 16'h4000, 4'b0000};
    v[3] = '{16'h3C00, 16'h3C00, 3'b111, 16'hBC00, 4'b0000};
    v[4] = '{16'h7E00, 16'h3C00, 3'b100, 16'h3C00, 4'b0000};
    v[5] = '{16'h8000, 16'h0000, 3'b100, 16'h8000, 4'b0000};
    v[6] = '{16'h8000, 16'h0000, 3'b101, 16'h0000, 4'b0000};
    v[7] = '{16'h7E00, 16'h7E00, 3'b101, 16'h7E00, 4'b0000};
    v[8] = '{16'hFE01, 16'h1234, 3'b110, 16'h7E01, 4'b0000};
    for (int i = 0; i <= 9; i++) begin
      if (i < 9) begin a = v[i].a; b = v[i].b; opc = v[i].opc; end
      @(posedge clk); #1;
      if (i >= 1) begin
        total++;
        if (op !== v[i-1].eop)
          begin bad++; $display("FAIL b2b[%0d] op got %h want %h", i-1, op, v[i-1].eop); end
        total++;
        if (edge_case !== v[i-1].efl)
          begin bad++; $display("FAIL b2b[%0d] flags got %b want %b", i-1, edge_case, v[i-1].efl); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; a = 16'h0; b = 16'h0; opc = 3'b000;
    test_reset;
    test_add_sub;
    test_mul;
    test_div;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
